prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Run controller for the core's program counter. It accepts a program launch request with a program select, loads that program's base address into the PC, and enables PC stepping until the decoder flags a halt instruction or a watchdog expires. It also reports busy/done/timeout status and the run-cycle count to the testbench/host. It sits between the top-level Start/ProgSel inputs and the PC's load/increment controls, and holds a small writable table of program base addresses.

## Interface
- A, 10, PC/address width
- NPROG, 4, number of programs in the base table (power of 2, ≥2)
- CW, 16, cycle counter width
- TIMEOUT, 1023, max RUN cycles before forced stop (1 ≤ TIMEOUT ≤ 2^CW−1)

- clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  launch request, level; acted on at its rising edge
- ProgSel  in  $clog2(NPROG)  program index, sampled on the Start rising edge
- Halt  in  1  decoder asserts while the current instruction is a halt
- CfgWe  in  1  base-table write enable
- CfgIdx  in  $clog2(NPROG)  base-table write index
- CfgAddr  in  A  base-table write data
- PcLoad  out  1  one-cycle pulse: PC loads PcLoadAddr
- PcLoadAddr  out  A  base address of the selected program
- PcRun  out  1  PC increments/jumps only while high
- Busy  out  1  high in LOAD and RUN
- Done  out  1  high in DONE
- Timeout  out  1  high in DONE when the run ended by watchdog
- CycleCount  out  CW  RUN cycles of the current/last run

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset state is IDLE.
- Rising-edge detect: `start_q` registers Start, reset value 1. A rising edge is Start & ~start_q. Start held high through reset release does not launch.
- IDLE or DONE + rising edge → LOAD. The block latches ProgSel into `sel_q` and clears CycleCount, Timeout and Done.
- LOAD: lasts 1 cycle. PcLoad=1, PcLoadAddr=table[sel_q], PcRun=0. Then → RUN.
- RUN: PcRun=1. CycleCount increments every RUN cycle, including the exit cycle, and saturates at 2^CW−1.
  - Halt=1 → DONE, Timeout stays 0.
  - Else if CycleCount == TIMEOUT−1 (pre-increment value) → DONE, Timeout=1.
  - Halt has priority over the watchdog in the same cycle.
- DONE: PcRun=0. Done, Timeout and CycleCount are held until the next launch.
- Start edges in LOAD/RUN are ignored. They are not queued.
- PcLoadAddr is driven combinationally from table[sel_q] in every state. It is valid only when PcLoad=1.
- Base table:
  - NPROG×A registers. Reset value of entry i = i·(2^A/NPROG); for defaults this is 0, 256, 512, 768.
  - Writes are accepted only in IDLE or DONE. In LOAD/RUN the write is dropped silently.
  - A write in the same cycle as a launch edge is accepted, and LOAD (next cycle) sees the new value.
- Reset asserted in any state: the next state is IDLE, all outputs go to their reset values immediately (asynchronously), and the table returns to its defaults.

## Timing
- Reset values: PcLoad=0, PcLoadAddr=table[0]=0, PcRun=0, Busy=0, Done=0, Timeout=0, CycleCount=0.
- All outputs are registered state decodes or registers. There are no combinational paths from inputs to outputs, except PcLoadAddr via sel_q (registered).
- Launch latency: Start rises before edge k. LOAD (PcLoad=1) is in cycle k+1 and the first RUN cycle is k+2.
- Halt sampled high in RUN cycle n: Done=1 from cycle n+1, PcRun=0 from cycle n+1, CycleCount = number of RUN cycles including n.
- Watchdog run: exactly TIMEOUT RUN cycles, then Done=1, Timeout=1, CycleCount=TIMEOUT.
- Minimum relaunch: a Start rising edge in the first DONE cycle is honoured.

## Test plan
- Reset/idle: hold Reset=0 with Start=1, then release it with Start still 1. Required: no launch, all outputs 0. Drop Start and raise it again: PcLoad pulses 1 cycle with PcLoadAddr per ProgSel.
- Normal run: ProgSel=2, Start edge, Halt asserted on the 5th RUN cycle. Required: PcLoadAddr=512, PcRun high for exactly 5 cycles, Done=1, Timeout=0, CycleCount=5.
- Watchdog: TIMEOUT=8, Halt never asserted. Required: 8 RUN cycles, Done=1, Timeout=1, CycleCount=8. Also assert Halt on the 8th cycle: Timeout=0, CycleCount=8.
- Config: in IDLE write CfgIdx=1, CfgAddr=0x3F0, then launch ProgSel=1. Required: PcLoadAddr=0x3F0. A write during RUN to idx 1 = 0x010 is ignored and the next launch still loads 0x3F0. A write in the same cycle as the launch edge is used by that LOAD.
- Mid-run events: a Start edge during RUN causes no change. Deasserting Reset for one cycle mid-RUN clears everything immediately and restores the table to its defaults (idx 1 = 256).
- Back-to-back: a Start edge in the first DONE cycle relaunches. Required: Done drops, CycleCount clears, and LOAD follows on the next cycle.

Source files
------------

// File: rtl/prog_sequencer.sv
// Run controller for the core PC: launches a selected program, lets the PC step
// until a halt or watchdog expiry, and keeps a small writable base-address table.
module prog_sequencer #(
  parameter int A       = 10,
  parameter int NPROG   = 4,
  parameter int CW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [$clog2(NPROG)-1:0] ProgSel,
  input  logic                     Halt,
  input  logic                     CfgWe,
  input  logic [$clog2(NPROG)-1:0] CfgIdx,
  input  logic [A-1:0]             CfgAddr,
  output logic                     PcLoad,
  output logic [A-1:0]             PcLoadAddr,
  output logic                     PcRun,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Timeout,
  output logic [CW-1:0]            CycleCount
);

  // state | meaning
  // IDLE  | waiting for the first launch after reset
  // LOAD  | one cycle, PC loads the selected base address
  // RUN   | PC stepping, cycle counter and watchdog active
  // DONE  | run finished, status held until the next launch
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int SW   = $clog2(NPROG);
  localparam int STEP = (1 << A) / NPROG;

  state_t          state_q, state_d;
  logic            start_q;
  logic [SW-1:0]   sel_q;
  logic [CW-1:0]   cycle_q;
  logic            timeout_q;
  logic [A-1:0]    base_q [NPROG];

  logic            idle_or_done;
  logic            launch;
  logic            wd_hit;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign launch       = Start && !start_q && idle_or_done;
  assign wd_hit       = (cycle_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (Halt || wd_hit) state_d = DONE;
      DONE:    if (launch) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PcLoad = 1'b0;
    PcRun  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (state_q)
      LOAD: begin
        PcLoad = 1'b1;
        Busy   = 1'b1;
      end
      RUN: begin
        PcRun = 1'b1;
        Busy  = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  // start_q resets high so a Start held through reset release is not an edge
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      start_q   <= 1'b1;
      sel_q     <= '0;
      cycle_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      start_q <= Start;
      if (launch) begin
        sel_q     <= ProgSel;
        cycle_q   <= '0;
        timeout_q <= 1'b0;
      end else if (state_q == RUN) begin
        if (cycle_q != {CW{1'b1}}) cycle_q <= cycle_q + 1'b1;
        if (!Halt && wd_hit) timeout_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NPROG; i++) base_q[i] <= A'(i * STEP);
    end else if (CfgWe && idle_or_done) begin
      base_q[CfgIdx] <= CfgAddr;
    end
  end

  assign PcLoadAddr = base_q[sel_q];
  assign Timeout    = timeout_q;
  assign CycleCount = cycle_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer (TIMEOUT=8): reset, runs, watchdog,
// base-table config, mid-run events and back-to-back relaunch.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  ProgSel;
  logic        Halt;
  logic        CfgWe;
  logic [1:0]  CfgIdx;
  logic [9:0]  CfgAddr;
  logic        PcLoad;
  logic [9:0]  PcLoadAddr;
  logic        PcRun;
  logic        Busy;
  logic        Done;
  logic        Timeout;
  logic [15:0] CycleCount;

  int checks = 0;
  int errors = 0;

  prog_sequencer #(.A(10), .NPROG(4), .CW(16), .TIMEOUT(8)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .CfgWe(CfgWe), .CfgIdx(CfgIdx), .CfgAddr(CfgAddr),
    .PcLoad(PcLoad), .PcLoadAddr(PcLoadAddr), .PcRun(PcRun), .Busy(Busy),
    .Done(Done), .Timeout(Timeout), .CycleCount(CycleCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b1; ProgSel = 2'd3; Halt = 1'b0;
    CfgWe = 1'b0; CfgIdx = '0; CfgAddr = '0;
    repeat (3) tick();
    checks++;
    if ({PcLoad, PcRun, Busy, Done, Timeout} !== 5'b0 || CycleCount !== 16'd0 || PcLoadAddr !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b cc=%0d addr=%0d, required flags=00000 cc=0 addr=0",
               {PcLoad, PcRun, Busy, Done, Timeout}, CycleCount, PcLoadAddr);
    end
    Reset = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (PcLoad !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_no_launch: PcLoad=%b Busy=%b, required 0 0", PcLoad, Busy);
      end
    end
    Start = 1'b0;
    tick();
    Start = 1'b1;
    tick();
    checks++;
    if (PcLoad !== 1'b1 || PcLoadAddr !== 10'd768) begin
      errors++;
      $display("FAIL reset_first_launch: PcLoad=%b addr=%0d, required 1 768", PcLoad, PcLoadAddr);
    end
    tick();
    checks++;
    if (PcLoad !== 1'b0 || PcRun !== 1'b1) begin
      errors++;
      $display("FAIL reset_load_one_cycle: PcLoad=%b PcRun=%b, required 0 1", PcLoad, PcRun);
    end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    Start = 1'b0;
  endtask

  task automatic test_normal_run();
    tick();
    ProgSel = 2'd2;
    Start = 1'b1;
    tick();
    checks++;
    if (PcLoad !== 1'b1 || PcLoadAddr !== 10'd512 || PcRun !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL normal_load: PcLoad=%b addr=%0d PcRun=%b Done=%b, required 1 512 0 0",
               PcLoad, PcLoadAddr, PcRun, Done);
    end
    Start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (PcRun !== 1'b1 || CycleCount !== 16'(i - 1)) begin
        errors++;
        $display("FAIL normal_run_cycle%0d: PcRun=%b cc=%0d, required 1 %0d", i, PcRun, CycleCount, i - 1);
      end
      if (i == 5) Halt = 1'b1;
    end
    tick();
    Halt = 1'b0;
    checks++;
    if (Done !== 1'b1 || PcRun !== 1'b0 || Timeout !== 1'b0 || CycleCount !== 16'd5 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL normal_done: Done=%b PcRun=%b Timeout=%b cc=%0d Busy=%b, required 1 0 0 5 0",
               Done, PcRun, Timeout, CycleCount, Busy);
    end
    tick();
    checks++;
    if (Done !== 1'b1 || CycleCount !== 16'd5) begin
      errors++;
      $display("FAIL normal_done_hold: Done=%b cc=%0d, required 1 5", Done, CycleCount);
    end
  endtask

  task automatic test_watchdog();
    int runs;
    ProgSel = 2'd0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    runs = 0;
    tick();
    while (PcRun === 1'b1 && runs < 20) begin
      runs++;
      tick();
    end
    checks++;
    if (runs !== 8 || Done !== 1'b1 || Timeout !== 1'b1 || CycleCount !== 16'd8) begin
      errors++;
      $display("FAIL watchdog_expire: runs=%0d Done=%b Timeout=%b cc=%0d, required 8 1 1 8",
               runs, Done, Timeout, CycleCount);
    end
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 8) begin
        checks++;
        if (PcRun !== 1'b1 || CycleCount !== 16'd7) begin
          errors++;
          $display("FAIL watchdog_last_cycle: PcRun=%b cc=%0d, required 1 7", PcRun, CycleCount);
        end
        Halt = 1'b1;
      end
    end
    tick();
    Halt = 1'b0;
    checks++;
    if (Done !== 1'b1 || Timeout !== 1'b0 || CycleCount !== 16'd8) begin
      errors++;
      $display("FAIL watchdog_halt_priority: Done=%b Timeout=%b cc=%0d, required 1 0 8",
               Done, Timeout, CycleCount);
    end
  endtask

  task automatic test_config();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    CfgWe = 1'b1; CfgIdx = 2'd1; CfgAddr = 10'h3F0;
    tick();
    CfgWe = 1'b0;
    ProgSel = 2'd1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (PcLoad !== 1'b1 || PcLoadAddr !== 10'h3F0) begin
      errors++;
      $display("FAIL cfg_idle_write: PcLoad=%b addr=%h, required 1 3f0", PcLoad, PcLoadAddr);
    end
    tick();
    CfgWe = 1'b1; CfgIdx = 2'd1; CfgAddr = 10'h010;
    tick();
    CfgWe = 1'b0;
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (PcLoad !== 1'b1 || PcLoadAddr !== 10'h3F0) begin
      errors++;
      $display("FAIL cfg_run_write_dropped: PcLoad=%b addr=%h, required 1 3f0", PcLoad, PcLoadAddr);
    end
    tick();
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    CfgWe = 1'b1; CfgIdx = 2'd2; CfgAddr = 10'h155;
    ProgSel = 2'd2;
    Start = 1'b1;
    tick();
    CfgWe = 1'b0;
    Start = 1'b0;
    checks++;
    if (PcLoad !== 1'b1 || PcLoadAddr !== 10'h155) begin
      errors++;
      $display("FAIL cfg_same_cycle_write: PcLoad=%b addr=%h, required 1 155", PcLoad, PcLoadAddr);
    end
    tick();
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
  endtask

  task automatic test_midrun();
    tick();
    ProgSel = 2'd0;
    Start = 1'b1;
    tick();
    tick();
    Start = 1'b0;
    tick();
    Start = 1'b1;
    tick();
    checks++;
    if (PcRun !== 1'b1 || PcLoad !== 1'b0 || CycleCount !== 16'd2) begin
      errors++;
      $display("FAIL midrun_start_ignored: PcRun=%b PcLoad=%b cc=%0d, required 1 0 2", PcRun, PcLoad, CycleCount);
    end
    tick();
    checks++;
    if (PcRun !== 1'b1 || PcLoad !== 1'b0 || CycleCount !== 16'd3) begin
      errors++;
      $display("FAIL midrun_continue: PcRun=%b PcLoad=%b cc=%0d, required 1 0 3", PcRun, PcLoad, CycleCount);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({PcLoad, PcRun, Busy, Done, Timeout} !== 5'b0 || CycleCount !== 16'd0) begin
      errors++;
      $display("FAIL midrun_async_reset: flags=%b cc=%0d, required flags=00000 cc=0",
               {PcLoad, PcRun, Busy, Done, Timeout}, CycleCount);
    end
    tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_launch_after_reset: Busy=%b, required 0", Busy);
    end
    Start = 1'b0;
    tick();
    ProgSel = 2'd1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (PcLoad !== 1'b1 || PcLoadAddr !== 10'd256) begin
      errors++;
      $display("FAIL midrun_table_default: PcLoad=%b addr=%0d, required 1 256", PcLoad, PcLoadAddr);
    end
    tick();
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
  endtask

  task automatic test_back_to_back();
    int runs;
    ProgSel = 2'd3;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    runs = 0;
    tick();
    while (PcRun === 1'b1 && runs < 20) begin
      runs++;
      tick();
    end
    checks++;
    if (Done !== 1'b1 || Timeout !== 1'b1 || CycleCount !== 16'd8) begin
      errors++;
      $display("FAIL b2b_first_done: Done=%b Timeout=%b cc=%0d, required 1 1 8", Done, Timeout, CycleCount);
    end
    Start = 1'b1;
    tick();
    checks++;
    if (Done !== 1'b0 || Timeout !== 1'b0 || CycleCount !== 16'd0 || PcLoad !== 1'b1 || PcLoadAddr !== 10'd768) begin
      errors++;
      $display("FAIL b2b_relaunch: Done=%b Timeout=%b cc=%0d PcLoad=%b addr=%0d, required 0 0 0 1 768",
               Done, Timeout, CycleCount, PcLoad, PcLoadAddr);
    end
    Start = 1'b0;
    tick();
    checks++;
    if (PcRun !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_run: PcRun=%b Busy=%b, required 1 1", PcRun, Busy);
    end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_normal_run();
    test_watchdog();
    test_config();
    test_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
